// File: rtl/shared_reg_arbiter.sv
// Shared register with round-robin write arbitration and a clear path.
// A four-state FSM (IDLE, GRANT, DONE, CLEAR) owns the register. Every
// output is registered, so each output changes only on a rising clk edge.
module shared_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  input  logic                     clr_req,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic                     busy,
  output logic                     wr_done,
  output logic                     clr_ack
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   win, win_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [WIDTH-1:0]   q_nxt, qbar_nxt;
  logic               busy_nxt, wr_done_nxt, clr_ack_nxt;

  logic               rr_found;
  logic [PTR_W-1:0]   rr_win;
  logic [PTR_W-1:0]   rr_cand;
  int                 rr_idx;
  logic [WIDTH-1:0]   win_data;

  // Advance the round-robin pointer one past the last winner, wrapping at N_REQ.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(N_REQ - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Round-robin search: first set req bit starting at ptr, upward modulo N_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_idx  = (int'(ptr) + i) % N_REQ;
      rr_cand = PTR_W'(rr_idx);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  // Select the latched winner's data slice; the winner is fixed for the whole write.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic; outputs default to idle pulses and held data.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    gnt_nxt     = '0;
    q_nxt       = q;
    qbar_nxt    = qbar;
    wr_done_nxt = 1'b0;
    clr_ack_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          // Clear wins over any pending write.
          state_nxt = CLEAR;
        end else if (rr_found) begin
          state_nxt        = GRANT;
          win_nxt          = rr_win;
          gnt_nxt[rr_win]  = 1'b1;
        end
      end
      GRANT: begin
        // req is not looked at here: a winner that drops req still completes.
        q_nxt       = win_data;
        qbar_nxt    = ~win_data;
        wr_done_nxt = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        ptr_nxt   = ptr_inc(win);
        state_nxt = IDLE;
      end
      CLEAR: begin
        q_nxt       = '0;
        qbar_nxt    = '1;
        clr_ack_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs; synchronous active-low reset overrides everything.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      gnt     <= '0;
      q       <= '0;
      qbar    <= '1;
      busy    <= 1'b0;
      wr_done <= 1'b0;
      clr_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win     <= win_nxt;
      gnt     <= gnt_nxt;
      q       <= q_nxt;
      qbar    <= qbar_nxt;
      busy    <= busy_nxt;
      wr_done <= wr_done_nxt;
      clr_ack <= clr_ack_nxt;
    end
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, giving the number of requesters.
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the width of the shared register.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port clear_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port req, input, N_REQ bits: write request, one bit per requester.
REQ-006 The module SHALL have port wdata, input, N_REQ*WIDTH bits: write data; slice i is bits [i*WIDTH +: WIDTH] and belongs to requester i.
REQ-007 The module SHALL have port clr_req, input, 1 bit: request to clear the shared register.
REQ-008 The module SHALL have port gnt, output, N_REQ bits: one-hot grant.
REQ-009 The module SHALL have port q, output, WIDTH bits: shared register value.
REQ-010 The module SHALL have port qbar, output, WIDTH bits: bitwise complement of q.
REQ-011 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The module SHALL have port wr_done, output, 1 bit: one-cycle pulse after a completed write.
REQ-013 The module SHALL have port clr_ack, output, 1 bit: one-cycle pulse after a completed clear.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, GRANT, DONE and CLEAR, all outputs registered.
REQ-015 In IDLE with clr_req=1 the FSM SHALL go to CLEAR, regardless of req; clear beats write.
REQ-016 In IDLE with clr_req=0 and req!=0 the FSM SHALL latch the round-robin winner and go to GRANT.
REQ-017 In IDLE with clr_req=0 and req=0 the FSM SHALL stay in IDLE.
REQ-018 Round-robin SHALL search from pointer ptr upward modulo N_REQ; the first set req bit wins.
REQ-019 The pointer ptr SHALL reset to 0.
REQ-020 In DONE, ptr SHALL update to (winner+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-021 In GRANT, gnt[winner] SHALL be 1 for exactly one cycle.
REQ-022 On the edge leaving GRANT, q SHALL load the winner's wdata slice and qbar its complement; then the FSM goes to DONE.
REQ-023 If req[winner] drops during GRANT, the write SHALL still complete; the winner is not re-evaluated.
REQ-024 In DONE, wr_done SHALL be 1 and gnt all-zero for one cycle; then the FSM returns to IDLE.
REQ-025 In CLEAR, on the exit edge, q SHALL become all-zero and qbar all-ones.
REQ-026 clr_ack SHALL be 1 during the cycle after CLEAR, and the FSM returns to IDLE at that edge.
REQ-027 clr_req is level-sampled in IDLE only; held high, it SHALL cause repeated clears.
REQ-028 clr_req asserted mid-write SHALL be serviced at the next IDLE.
REQ-029 A req still high in IDLE after DONE SHALL be re-arbitrated with the updated ptr, with no starvation.
REQ-030 Latency: req first seen in IDLE at edge k gives gnt during cycle k..k+1, q updated at edge k+1, and wr_done during cycle k+1..k+2.
REQ-031 Peak throughput SHALL be one write per 3 cycles.
REQ-032 q and qbar SHALL hold their value in all states except on GRANT and CLEAR exits.
REQ-033 gnt SHALL never have more than one bit set.

Reset
REQ-034 With clear_n=0 at a rising edge, the block SHALL set state=IDLE, ptr=0, gnt=0, q=0, qbar=all-ones, busy=0, wr_done=0 and clr_ack=0.
REQ-035 Reset SHALL take precedence over every input.
REQ-036 Reset mid-GRANT SHALL abort the write, leaving q=0 and no wr_done.
REQ-037 All other outputs SHALL change only on clk rising edges.

Verification
REQ-038 Reset, then req=4'b0001 with wdata slice0=8'hA5 -> gnt=0001 for 1 cycle, q=8'hA5, qbar=8'h5A, then a wr_done pulse.
REQ-039 req=4'b1111 held, slices 8'h10/8'h20/8'h30/8'h40 -> grant order 0,1,2,3,0, with q following and each wr_done 3 cycles apart.
REQ-040 ptr=3 after a grant to 2, with req=4'b1001 -> grant to 3, then to 0 (wrap-around).
REQ-041 clr_req=1 and req=4'b0010 both high in IDLE, with q=8'hFF -> CLEAR first, q=8'h00, qbar=8'hFF, clr_ack pulse; grant to 1 follows.
REQ-042 clear_n=0 during GRANT (wdata slice=8'h77) -> q=8'h00, gnt=0, no wr_done, state IDLE.
REQ-043 req drops in the GRANT cycle -> the write still lands and the wr_done pulse still occurs.
